int_frame_loader: RTL and testbench
===================================

# int_frame_loader

Intrinsic frame loader for the LDPC decoder array. It accepts raw two's-complement channel LLRs over a valid/ready stream and saturates each to the decoder's sign-magnitude message format. It drives the daisy-chained `load_add_in`/`int_in`/`pe_select` load bus of the PE_BLOCK columns, writing one full frame into the inactive intrinsic buffers while the decoder works on the active one. It tracks the PE frame id (`f_id`) to know when a loaded frame has been taken and when a swap arrived too early.

## Interface
- `L`, 32, intrinsic entries per PE block (addresses 0..L-1)
- `NUM_PE`, 6, PE blocks on the load chain; frame size = NUM_PE*L samples
- `ADDR_WIDTH`, 5, load address width; L <= 2^ADDR_WIDTH
- `MESSAGE_WIDTH`, 5, output message width (MSB sign, low MESSAGE_WIDTH-1 bits magnitude)
- `IN_WIDTH`, 8, raw LLR width, two's complement
- `clk` input 1 decoder clock; all logic on rising edge
- `reset` input 1 asynchronous, active-low reset
- `in_valid` input 1 upstream sample valid
- `in_data` input IN_WIDTH raw LLR sample
- `in_ready` output 1 loader can accept a sample this cycle
- `f_id` input 1 frame id (active buffer select) from PE blocks
- `load_add` output ADDR_WIDTH address driven to first PE `load_add_in`
- `int_out` output MESSAGE_WIDTH quantized message driven to first PE `int_in`
- `pe_select` output NUM_PE one-hot write strobe per PE column; all-zero when no write
- `frame_ready` output 1 complete frame resident in inactive buffer, awaiting swap
- `overrun` output 1 sticky: swap occurred before frame complete
- `frame_count` output 8 completed-frame counter, wraps 255->0

## Operation
- Clock is `clk`; reset is asynchronous, active-low, named `reset` (fixed decision).
- Counters: `addr_cnt` 0..L-1, `pe_cnt` 0..NUM_PE-1. Order: PE0 addresses 0..L-1, then PE1, …, PE(NUM_PE-1).
- States: LOAD (in_ready=1) and FULL (in_ready=0). After reset: LOAD, counters 0.
- Accept = in_valid & in_ready. On each accept: register load_add=addr_cnt, int_out=quant(in_data), pe_select=1<<pe_cnt; advance addr_cnt; on addr_cnt==L-1 wrap to 0 and advance pe_cnt.
- Last accept (pe_cnt==NUM_PE-1, addr_cnt==L-1): counters -> 0, state -> FULL, frame_ready=1, frame_count+1.
- Quantization: sign = in_data<0; mag = |in_data| saturated to 2^(MESSAGE_WIDTH-1)-1 (15 at defaults); most-negative input saturates to 15; zero -> all-zero (never negative zero).
- Swap detect: f_id_q registers f_id (reset 0); toggle = f_id != f_id_q at a clock edge.
- Toggle in FULL: state -> LOAD, frame_ready=0.
- Toggle in LOAD (any count, including 0): overrun=1 (sticky until reset), counters -> 0, state stays LOAD.
- Toggle on the same edge as the last accept: toggle wins. That sample is still written (pe_select pulses), but frame_ready stays 0, frame_count does not increment, overrun=1, counters -> 0, state stays LOAD.
- in_valid with in_data change while in_ready=0: ignored, no write.

## Timing
- Reset values: in_ready 0 while reset low, then 1 (LOAD); load_add 0, int_out 0, pe_select 0, frame_ready 0, overrun 0, frame_count 0.
- Latency: sample accepted at edge n appears on load_add/int_out/pe_select after edge n, valid for exactly one cycle; pe_select returns to 0 next cycle absent another accept.
- Throughput: one sample per cycle in LOAD; in_ready is a pure function of registered state (no combinational path from in_valid).
- frame_ready rises after the edge of the last accept; falls after the edge where the toggle is detected. in_ready rises the same edge.
- Minimum frame load: NUM_PE*L cycles (192 at defaults).

## Test plan
- Reset then stream 192 samples of value k mod 128 with in_valid=1 -> pe_select 000001 for addrs 0..31, …, 100000 for addrs 0..31; frame_ready=1 after 192nd accept; in_ready=0; frame_count=1.
- Quantization: inputs 0, 7, 15, 16, 127, -1, -15, -16, -128 -> int_out 00000, 00111, 01111, 01111, 01111, 10001, 11111, 11111, 11111.
- In FULL, toggle f_id 0->1 -> frame_ready=0, in_ready=1 next cycle; second frame loads from PE0 addr 0; frame_count=2 at its end.
- Toggle f_id after 50 accepts -> overrun=1, next accepted sample goes to PE0 addr 0 with pe_select 000001; overrun stays 1 through a full later frame.
- Toggle f_id on the same edge as accept 192 -> that write pulses pe_select 100000 addr 31; frame_ready stays 0; overrun=1; frame_count unchanged.
- Assert reset low mid-frame (after 100 accepts) -> all outputs return to reset values immediately; after release, loading restarts at PE0 addr 0.

Source files
------------

// File: rtl/int_frame_loader.sv
// rtl/int_frame_loader.sv - loads one saturated intrinsic frame into the inactive PE buffers
// Frame id toggles from the PE blocks mark buffer swaps; early swaps abort the load.
module int_frame_loader #(
  parameter int L             = 32,
  parameter int NUM_PE        = 6,
  parameter int ADDR_WIDTH    = 5,
  parameter int MESSAGE_WIDTH = 5,
  parameter int IN_WIDTH      = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [IN_WIDTH-1:0]      in_data,
  output logic                     in_ready,
  input  logic                     f_id,
  output logic [ADDR_WIDTH-1:0]    load_add,
  output logic [MESSAGE_WIDTH-1:0] int_out,
  output logic [NUM_PE-1:0]        pe_select,
  output logic                     frame_ready,
  output logic                     overrun,
  output logic [7:0]               frame_count
);

  localparam int PE_W  = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam int MAG_W = MESSAGE_WIDTH - 1;
  localparam logic [IN_WIDTH-1:0] MAG_MAX = IN_WIDTH'((1 << MAG_W) - 1);

  localparam logic [0:0] S_LOAD = 1'b0;
  localparam logic [0:0] S_FULL = 1'b1;

  logic [0:0]               state;
  logic [ADDR_WIDTH-1:0]    addr_cnt;
  logic [PE_W-1:0]          pe_cnt;
  logic                     f_id_q;
  logic                     toggle;
  logic                     accept;
  logic                     last;
  logic                     sign;
  logic [IN_WIDTH-1:0]      mag;
  logic [MAG_W-1:0]         mag_sat;
  logic [MESSAGE_WIDTH-1:0] quant;

  assign in_ready = reset & (state == S_LOAD);
  assign accept   = in_valid & in_ready;
  assign toggle   = f_id != f_id_q;
  assign last     = (pe_cnt == PE_W'(NUM_PE - 1)) && (addr_cnt == ADDR_WIDTH'(L - 1));

  // Two's complement to sign-magnitude; the most-negative input's magnitude
  // wraps to 2^(IN_WIDTH-1) as unsigned, which still exceeds MAG_MAX.
  always_comb begin
    sign    = in_data[IN_WIDTH-1];
    mag     = sign ? (~in_data + IN_WIDTH'(1)) : in_data;
    mag_sat = (mag > MAG_MAX) ? MAG_MAX[MAG_W-1:0] : mag[MAG_W-1:0];
    quant   = {sign, mag_sat};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_LOAD;
      addr_cnt    <= '0;
      pe_cnt      <= '0;
      f_id_q      <= 1'b0;
      load_add    <= '0;
      int_out     <= '0;
      pe_select   <= '0;
      frame_ready <= 1'b0;
      overrun     <= 1'b0;
      frame_count <= '0;
    end else begin
      f_id_q <= f_id;

      if (accept) begin
        load_add  <= addr_cnt;
        int_out   <= quant;
        pe_select <= NUM_PE'(1) << pe_cnt;
      end else begin
        pe_select <= '0;
      end

      // A swap takes priority over frame completion on the same edge.
      if (toggle) begin
        if (state == S_FULL) begin
          state       <= S_LOAD;
          frame_ready <= 1'b0;
        end else begin
          overrun <= 1'b1;
        end
        addr_cnt <= '0;
        pe_cnt   <= '0;
      end else if (accept) begin
        if (last) begin
          addr_cnt    <= '0;
          pe_cnt      <= '0;
          state       <= S_FULL;
          frame_ready <= 1'b1;
          frame_count <= frame_count + 8'd1;
        end else if (addr_cnt == ADDR_WIDTH'(L - 1)) begin
          addr_cnt <= '0;
          pe_cnt   <= pe_cnt + PE_W'(1);
        end else begin
          addr_cnt <= addr_cnt + ADDR_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_int_frame_loader.sv
// tb/tb_int_frame_loader.sv - directed vector bench for int_frame_loader
module tb_int_frame_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       f_id;
  logic [4:0] load_add;
  logic [4:0] int_out;
  logic [5:0] pe_select;
  logic       frame_ready;
  logic       overrun;
  logic [7:0] frame_count;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0] data;
    logic [4:0] q;
  } qvec_t;
  qvec_t qv[9];

  int_frame_loader dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .f_id(f_id), .load_add(load_add), .int_out(int_out),
    .pe_select(pe_select), .frame_ready(frame_ready), .overrun(overrun),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] qmodel(input int v);
    int m;
    logic [3:0] m4;
    if (v == 0) return 5'd0;
    m  = (v < 0) ? -v : v;
    if (m > 15) m = 15;
    m4 = m[3:0];
    return {v < 0, m4};
  endfunction

  // Presents one sample as the k-th of the frame and checks the write it produces.
  task automatic send_k(input logic [7:0] d, input int k, input logic [4:0] exp_q, input logic chk_q);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    chk("load_add", 32'(load_add), 32'(k % 32));
    chk("pe_select", 32'(pe_select), 32'(6'd1 << (k / 32)));
    if (chk_q) chk("int_out", 32'(int_out), 32'(exp_q));
  endtask

  task automatic fill(input int from, input int to);
    for (int k = from; k < to; k++) send_k(8'(k % 128), k, qmodel(k % 128), 1'b1);
  endtask

  initial begin
    qv[0] = '{8'd0,    5'b00000};
    qv[1] = '{8'd7,    5'b00111};
    qv[2] = '{8'd15,   5'b01111};
    qv[3] = '{8'd16,   5'b01111};
    qv[4] = '{8'd127,  5'b01111};
    qv[5] = '{8'hFF,   5'b10001};
    qv[6] = '{8'hF1,   5'b11111};
    qv[7] = '{8'hF0,   5'b11111};
    qv[8] = '{8'h80,   5'b11111};

    reset = 1'b0; in_valid = 1'b0; in_data = 8'd0; f_id = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst in_ready", 32'(in_ready), 0);
    chk("rst load_add", 32'(load_add), 0);
    chk("rst int_out", 32'(int_out), 0);
    chk("rst pe_select", 32'(pe_select), 0);
    chk("rst frame_ready", 32'(frame_ready), 0);
    chk("rst overrun", 32'(overrun), 0);
    chk("rst frame_count", 32'(frame_count), 0);
    reset = 1'b1;
    #1 chk("in_ready after reset", 32'(in_ready), 1);
    @(negedge clk);

    // Frame 1: full stream of k mod 128
    for (int k = 0; k < 192; k++) begin
      send_k(8'(k % 128), k, qmodel(k % 128), 1'b1);
      if (k < 191) chk("frame_ready early", 32'(frame_ready), 0);
    end
    chk("f1 frame_ready", 32'(frame_ready), 1);
    chk("f1 in_ready", 32'(in_ready), 0);
    chk("f1 frame_count", 32'(frame_count), 1);

    // Samples offered while FULL are ignored
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'(i + 40);
      @(negedge clk);
      chk("full pe_select", 32'(pe_select), 0);
      chk("full frame_ready", 32'(frame_ready), 1);
    end
    in_valid = 1'b0;

    // Swap in FULL
    f_id = 1'b1;
    @(negedge clk);
    chk("swap frame_ready", 32'(frame_ready), 0);
    chk("swap in_ready", 32'(in_ready), 1);
    chk("swap overrun", 32'(overrun), 0);

    // Frame 2: quantization table first, then filler
    for (int i = 0; i < 9; i++) send_k(qv[i].data, i, qv[i].q, 1'b1);
    fill(9, 192);
    chk("f2 frame_ready", 32'(frame_ready), 1);
    chk("f2 frame_count", 32'(frame_count), 2);
    in_valid = 1'b0;
    f_id = 1'b0;
    @(negedge clk);
    chk("swap2 frame_ready", 32'(frame_ready), 0);

    // Swap lands on the same edge as the last accept
    fill(0, 191);
    f_id = 1'b1;
    send_k(8'd5, 191, 5'b00101, 1'b1);
    chk("same-edge frame_ready", 32'(frame_ready), 0);
    chk("same-edge overrun", 32'(overrun), 1);
    chk("same-edge frame_count", 32'(frame_count), 2);
    chk("same-edge in_ready", 32'(in_ready), 1);
    send_k(8'd3, 0, 5'b00011, 1'b1);

    // Reset mid-frame after 100 accepts
    fill(1, 100);
    @(posedge clk); #2;
    reset = 1'b0; f_id = 1'b0;
    #1;
    chk("mid rst in_ready", 32'(in_ready), 0);
    chk("mid rst load_add", 32'(load_add), 0);
    chk("mid rst int_out", 32'(int_out), 0);
    chk("mid rst pe_select", 32'(pe_select), 0);
    chk("mid rst overrun", 32'(overrun), 0);
    chk("mid rst frame_count", 32'(frame_count), 0);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    send_k(8'hF8, 0, 5'b11000, 1'b1);

    // Early swap after 50 accepts
    fill(1, 50);
    in_valid = 1'b0;
    f_id = 1'b1;
    @(negedge clk);
    chk("early overrun", 32'(overrun), 1);
    chk("early in_ready", 32'(in_ready), 1);
    chk("early frame_ready", 32'(frame_ready), 0);
    fill(0, 192);
    chk("post frame_ready", 32'(frame_ready), 1);
    chk("post frame_count", 32'(frame_count), 1);
    chk("post overrun sticky", 32'(overrun), 1);
    in_valid = 1'b0;
    f_id = 1'b0;
    @(negedge clk);
    chk("post swap frame_ready", 32'(frame_ready), 0);
    chk("post swap overrun", 32'(overrun), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
